sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Parametrised successor to the board-level switch logic, which maps raw switch inputs directly onto LEDs.
- Conditions N raw board switches or buttons per channel: 2-flop synchroniser, stability-counter debounce, rise/fall pulse generation, and a per-channel LED output selectable between level mode and toggle (latch) mode.
- Sits between the board `sw`/`btn` pins and the `ledr` outputs and user logic in `top`.

Parameters:
- N, 16, number of independent channels.
- CNT_W, 20, width of each channel's stability counter.
- STABLE, 1000000, consecutive mismatching cycles required before the debounced level changes. Range 1..2^CNT_W.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset. 0 = reset asserted.
- sw_in  input  N  raw asynchronous switch/button levels.
- mode  input  N  per-channel LED mode. 0 = level, 1 = toggle. Sampled every cycle.
- clr  input  1  synchronous clear of all toggle registers.
- level  output  N  debounced level, registered.
- rise  output  N  one-cycle pulse on a debounced 0->1 transition, registered.
- fall  output  N  one-cycle pulse on a debounced 1->0 transition, registered.
- led  output  N  per channel: mode ? toggle state : level.
- any_change  output  1  OR-reduction of (rise | fall).

Behaviour:
- Reset (rst=0, asynchronous): sync stages, counters, level, rise, fall and toggle all go to 0. Consequently led=0 and any_change=0. Reset asserted mid-count discards all progress.
- Synchroniser: s1 <= sw_in; s2 <= s1. Only s2 is used downstream.
- Counter, per channel, each edge:
  - If s2 == level: cnt <= 0.
  - Else if cnt == STABLE-1: level <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency:
  - A change at sw_in that is stable before edge 0 appears on level after edge STABLE+2.
  - A level that returns to match before that point resets the counter, so no output change occurs.
  - cnt never exceeds STABLE-1; there is no wrap-around.
- Pulses:
  - rise <= s2 & ~level & (cnt==STABLE-1) & mismatch; fall is the analogue for 1->0.
  - Each pulse asserts in the same cycle level changes and lasts exactly 1 cycle.
  - rise and fall are never both high on one channel.
- Toggle register, per channel, each edge:
  - If clr: toggle <= 0. clr has priority over a simultaneous rise.
  - Else if rise & mode: toggle <= ~toggle.
  - rise while mode=0 leaves toggle unchanged.
  - fall never affects toggle.
- led is a combinational mux of registered signals. Changing mode switches led in the same cycle with no glitch filtering; toggle state is retained across mode changes.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Post-reset: if sw_in is held at 1 through reset release, level rises STABLE+2 edges after release and emits a rise pulse. This is intended behaviour.
- STABLE=1: level follows s2 with 1 cycle of extra delay (3 edges from sw_in).

Test Plan:
1. N=4, STABLE=4: hold rst=0, then release with sw_in=0000 -> all outputs 0 indefinitely.
2. sw_in[0] 0->1, held -> level[0]=1 after edge 6; rise[0]=1 for exactly that cycle; any_change=1 for that cycle; fall and other channels stay 0.
3. sw_in[1] pulse high for 3 cycles (shorter than STABLE+2) -> level[1], rise[1] and led[1] never change. Repeated 3-on/1-off bounce for 20 cycles, then held high -> level[1]=1 exactly 6 edges after the final rising edge of sw_in.
4. mode[2]=1; press-and-release sw_in[2] twice, each phase held 10 cycles -> led[2] goes 1 after the first press, 0 after the second, and ignores releases. level[2] still tracks the switch.
5. mode[3]=1, toggle[3]=1; assert clr in the same cycle as rise[3] -> led[3]=0 next cycle. Then set mode[3]=0 -> led[3] equals level[3] immediately.
6. Assert rst=0 mid-count (cnt[0]=2) and mid-toggle -> all outputs 0 asynchronously, before the next clk edge. After release, sw_in[0]=1 still held -> rise[0] at edge 6 after release.

Source files
------------

// File: rtl/sw_debounce.sv
// Per-channel switch conditioning: 2-flop synchroniser, stability-count debounce,
// registered rise/fall pulses and an LED output selectable between level and toggle.
module sw_debounce #(
  parameter int N      = 16,
  parameter int CNT_W  = 20,
  parameter int STABLE = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_in,
  input  logic [N-1:0] mode,
  input  logic         clr,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] led,
  output logic         any_change
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(STABLE - 1);

  logic [N-1:0]     s1_q, s1_d;
  logic [N-1:0]     s2_q, s2_d;
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     tog_q, tog_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    s1_d    = sw_in;
    s2_d    = s1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    tog_d   = tog_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      // The counter only runs while the synchronised input disagrees with level.
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TC) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // Toggle reacts to the visible rise pulse, so it lags level by one cycle.
      if (clr) begin
        tog_d[i] = 1'b0;
      end else if (rise_q[i] && mode[i]) begin
        tog_d[i] = ~tog_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      tog_q   <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tog_q   <= tog_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign led        = (mode & tog_q) | (~mode & level_q);
  assign any_change = |(rise_q | fall_q);

endmodule
